// File: rtl/hazard_detection_unit_pkg.sv
// Shared definitions for the hazard detection unit: FSM state encodings,
// the zero-register constant and the four-bit pipeline control bundle.
package hazard_detection_unit_pkg;

  typedef enum logic [1:0] {
    HZ_NORMAL = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FLUSH  = 2'd2
  } hz_state_e;

  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic escreve_pc;
    logic escreve_if_id;
    logic bolha_id_ex;
    logic limpa_if_id;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0};
  localparam hz_ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam hz_ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1};
  localparam hz_ctrl_t CTRL_RESET = '{1'b0, 1'b0, 1'b1, 1'b1};

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline-side signals of the hazard detection unit: ID/EX comparison
// inputs in, stall/flush controls and statistics counters out.
interface hazard_detection_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] IF_ID_rs;
  logic [REG_W-1:0] IF_ID_rt;
  logic             IF_ID_UsaRt;
  logic [REG_W-1:0] ID_EX_rt;
  logic             ID_EX_LeMem;
  logic             EX_DesvioTomado;
  logic             EscrevePC;
  logic             EscreveIF_ID;
  logic             BolhaID_EX;
  logic             LimpaIF_ID;
  logic [CNT_W-1:0] ContBolhas;
  logic [CNT_W-1:0] ContDescartes;

  modport master (
    output IF_ID_rs, IF_ID_rt, IF_ID_UsaRt, ID_EX_rt, ID_EX_LeMem, EX_DesvioTomado,
    input  EscrevePC, EscreveIF_ID, BolhaID_EX, LimpaIF_ID, ContBolhas, ContDescartes
  );

  modport slave (
    input  IF_ID_rs, IF_ID_rt, IF_ID_UsaRt, ID_EX_rt, ID_EX_LeMem, EX_DesvioTomado,
    output EscrevePC, EscreveIF_ID, BolhaID_EX, LimpaIF_ID, ContBolhas, ContDescartes
  );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush control for the ID stage, with
// saturating bubble/discard statistics.
module hazard_detection_unit #(
  parameter int REG_W          = 5,
  parameter int LOAD_STALL     = 1,
  parameter int BRANCH_PENALTY = 1,
  parameter int CNT_W          = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  hazard_detection_unit_if.slave hz
);
   import hazard_detection_unit_pkg::*;

   localparam int CNT_BITS = $clog2(max_int(LOAD_STALL, BRANCH_PENALTY)) + 1;

   hz_state_e           state;
   logic [CNT_BITS-1:0] cnt;
   logic                load_use;
   hz_ctrl_t            ctrl;

   assign load_use = hz.ID_EX_LeMem
                   && (hz.ID_EX_rt != REG_W'(REG_ZERO))
                   && ((hz.ID_EX_rt == hz.IF_ID_rs)
                       || (hz.IF_ID_UsaRt && (hz.ID_EX_rt == hz.IF_ID_rt)));

   // Taken branch wins in every state: the instruction in ID is wrong-path.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state <= HZ_NORMAL;
         cnt   <= '0;
      end else if (hz.EX_DesvioTomado) begin
         if (BRANCH_PENALTY > 1) begin
            state <= HZ_FLUSH;
            cnt   <= CNT_BITS'(BRANCH_PENALTY - 1);
         end else begin
            state <= HZ_NORMAL;
            cnt   <= '0;
         end
      end else begin
         case (state)
            HZ_NORMAL: begin
               if (load_use && (LOAD_STALL > 1)) begin
                  state <= HZ_STALL;
                  cnt   <= CNT_BITS'(LOAD_STALL - 1);
               end
            end
            HZ_STALL, HZ_FLUSH: begin
               if (cnt == CNT_BITS'(1)) state <= HZ_NORMAL;
               cnt <= cnt - CNT_BITS'(1);
            end
            default: begin
               state <= HZ_NORMAL;
               cnt   <= '0;
            end
         endcase
      end
   end

   // NOTE: ctrl gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      ctrl = CTRL_RUN;
      if (!reset) begin
         ctrl = CTRL_RESET;
      end else if (hz.EX_DesvioTomado) begin
         ctrl = CTRL_FLUSH;
      end else begin
         case (state)
            HZ_NORMAL: ctrl = load_use ? CTRL_STALL : CTRL_RUN;
            HZ_STALL:  ctrl = CTRL_STALL;
            HZ_FLUSH:  ctrl = CTRL_FLUSH;
            default:   ctrl = CTRL_RUN;
         endcase
      end
   end

   assign hz.EscrevePC    = ctrl.escreve_pc;
   assign hz.EscreveIF_ID = ctrl.escreve_if_id;
   assign hz.BolhaID_EX   = ctrl.bolha_id_ex;
   assign hz.LimpaIF_ID   = ctrl.limpa_if_id;

   sat_counter #(.CNT_W(CNT_W)) u_cont_bolhas (
      .clock (clock),
      .reset (reset),
      .inc   (ctrl.bolha_id_ex),
      .count (hz.ContBolhas)
   );

   sat_counter #(.CNT_W(CNT_W)) u_cont_descartes (
      .clock (clock),
      .reset (reset),
      .inc   (hz.EX_DesvioTomado),
      .count (hz.ContDescartes)
   );

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench: dut_a uses LOAD_STALL=1/BRANCH_PENALTY=1, dut_b uses
// LOAD_STALL=3/BRANCH_PENALTY=2. Control outputs are checked as {PC,IF_ID,Bolha,Limpa}.
module tb_hazard_detection_unit;

   logic clock = 1'b0;
   logic rst_a;
   logic rst_b;
   int   total = 0;
   int   bad   = 0;

   localparam logic [3:0] RUN   = 4'b1100;
   localparam logic [3:0] STALL = 4'b0010;
   localparam logic [3:0] FLUSH = 4'b1111;
   localparam logic [3:0] RST   = 4'b0011;

   always #5 clock = ~clock;

   hazard_detection_unit_if #(.REG_W(5), .CNT_W(16)) ifa ();
   hazard_detection_unit_if #(.REG_W(5), .CNT_W(16)) ifb ();

   hazard_detection_unit #(.REG_W(5), .LOAD_STALL(1), .BRANCH_PENALTY(1), .CNT_W(16)) dut_a (
      .clock (clock),
      .reset (rst_a),
      .hz    (ifa.slave)
   );

   hazard_detection_unit #(.REG_W(5), .LOAD_STALL(3), .BRANCH_PENALTY(2), .CNT_W(16)) dut_b (
      .clock (clock),
      .reset (rst_b),
      .hz    (ifb.slave)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic edge_step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_a();
      ifa.IF_ID_rs = '0; ifa.IF_ID_rt = '0; ifa.IF_ID_UsaRt = 1'b0;
      ifa.ID_EX_rt = '0; ifa.ID_EX_LeMem = 1'b0; ifa.EX_DesvioTomado = 1'b0;
   endtask

   task automatic idle_b();
      ifb.IF_ID_rs = '0; ifb.IF_ID_rt = '0; ifb.IF_ID_UsaRt = 1'b0;
      ifb.ID_EX_rt = '0; ifb.ID_EX_LeMem = 1'b0; ifb.EX_DesvioTomado = 1'b0;
   endtask

   function automatic logic [3:0] ctl_a();
      return {ifa.EscrevePC, ifa.EscreveIF_ID, ifa.BolhaID_EX, ifa.LimpaIF_ID};
   endfunction

   function automatic logic [3:0] ctl_b();
      return {ifb.EscrevePC, ifb.EscreveIF_ID, ifb.BolhaID_EX, ifb.LimpaIF_ID};
   endfunction

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      idle_a();
      idle_b();
      #1;
      check("reset_outputs_a", ctl_a(), RST);
      check("reset_outputs_b", ctl_b(), RST);
      edge_step();
      edge_step();
      check("reset_bolhas_a", ifa.ContBolhas, 0);
      check("reset_descartes_a", ifa.ContDescartes, 0);
      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      check("normal_a", ctl_a(), RUN);
      check("normal_b", ctl_b(), RUN);

      // lw $2 in EX, ID reads rs=$2, single bubble
      ifa.ID_EX_LeMem = 1'b1; ifa.ID_EX_rt = 5'd2; ifa.IF_ID_rs = 5'd2;
      #1;
      check("lu_rs_stall", ctl_a(), STALL);
      edge_step();
      idle_a();
      #1;
      check("lu_rs_release", ctl_a(), RUN);
      check("lu_rs_bolhas", ifa.ContBolhas, 1);

      // $0 never stalls; rt only matters when UsaRt is set
      ifa.ID_EX_LeMem = 1'b1; ifa.ID_EX_rt = 5'd0; ifa.IF_ID_rs = 5'd0;
      #1;
      check("lu_zero_reg", ctl_a(), RUN);
      ifa.ID_EX_rt = 5'd2; ifa.IF_ID_rs = 5'd5; ifa.IF_ID_rt = 5'd2; ifa.IF_ID_UsaRt = 1'b0;
      #1;
      check("lu_rt_unused", ctl_a(), RUN);
      ifa.IF_ID_UsaRt = 1'b1;
      #1;
      check("lu_rt_used", ctl_a(), STALL);
      ifa.ID_EX_LeMem = 1'b0;
      #1;
      check("lu_not_load", ctl_a(), RUN);
      idle_a();
      edge_step();
      check("lu_bolhas_hold", ifa.ContBolhas, 1);

      // LOAD_STALL=3: three bubbles, load_use ignored once in STALL
      ifb.ID_EX_LeMem = 1'b1; ifb.ID_EX_rt = 5'd7; ifb.IF_ID_rs = 5'd7;
      #1;
      check("ls3_cycle1", ctl_b(), STALL);
      edge_step();
      idle_b();
      #1;
      check("ls3_cycle2", ctl_b(), STALL);
      edge_step();
      check("ls3_cycle3", ctl_b(), STALL);
      edge_step();
      check("ls3_done", ctl_b(), RUN);
      check("ls3_bolhas", ifb.ContBolhas, 3);

      // BRANCH_PENALTY=2: branch and load_use together, flush wins
      ifb.ID_EX_LeMem = 1'b1; ifb.ID_EX_rt = 5'd7; ifb.IF_ID_rs = 5'd7; ifb.EX_DesvioTomado = 1'b1;
      #1;
      check("bp2_cycle1", ctl_b(), FLUSH);
      edge_step();
      idle_b();
      #1;
      check("bp2_cycle2", ctl_b(), FLUSH);
      edge_step();
      check("bp2_done", ctl_b(), RUN);
      check("bp2_descartes", ifb.ContDescartes, 1);
      check("bp2_bolhas", ifb.ContBolhas, 5);

      // Taken branch mid-STALL restarts a full FLUSH
      ifb.ID_EX_LeMem = 1'b1; ifb.ID_EX_rt = 5'd4; ifb.IF_ID_rs = 5'd4;
      #1;
      check("sb_stall", ctl_b(), STALL);
      edge_step();
      idle_b();
      ifb.EX_DesvioTomado = 1'b1;
      #1;
      check("sb_branch", ctl_b(), FLUSH);
      edge_step();
      idle_b();
      #1;
      check("sb_flush", ctl_b(), FLUSH);
      edge_step();
      check("sb_done", ctl_b(), RUN);
      check("sb_bolhas", ifb.ContBolhas, 8);
      check("sb_descartes", ifb.ContDescartes, 2);

      // Reset in the 2nd cycle of a 3-cycle STALL aborts it
      ifb.ID_EX_LeMem = 1'b1; ifb.ID_EX_rt = 5'd3; ifb.IF_ID_rs = 5'd3;
      #1;
      check("rs_stall1", ctl_b(), STALL);
      edge_step();
      idle_b();
      #1;
      check("rs_stall2", ctl_b(), STALL);
      rst_b = 1'b0;
      #1;
      check("rs_forced", ctl_b(), RST);
      edge_step();
      check("rs_held", ctl_b(), RST);
      check("rs_bolhas_clr", ifb.ContBolhas, 0);
      check("rs_descartes_clr", ifb.ContDescartes, 0);
      rst_b = 1'b1;
      #1;
      check("rs_release", ctl_b(), RUN);
      edge_step();
      check("rs_no_residual", ctl_b(), RUN);
      check("rs_bolhas_after", ifb.ContBolhas, 0);

      // Saturation: 2^16+5 cycles of taken branch on dut_a
      rst_a = 1'b0;
      edge_step();
      rst_a = 1'b1;
      ifa.EX_DesvioTomado = 1'b1;
      #1;
      check("sat_outputs", ctl_a(), FLUSH);
      repeat (65534) @(posedge clock);
      #1;
      check("sat_bolhas_fffe", ifa.ContBolhas, 16'hFFFE);
      check("sat_descartes_fffe", ifa.ContDescartes, 16'hFFFE);
      repeat (7) @(posedge clock);
      #1;
      check("sat_bolhas_ffff", ifa.ContBolhas, 16'hFFFF);
      check("sat_descartes_ffff", ifa.ContDescartes, 16'hFFFF);
      check("sat_outputs_late", ctl_a(), FLUSH);
      idle_a();
      #1;
      check("sat_release", ctl_a(), RUN);
      edge_step();
      check("sat_bolhas_hold", ifa.ContBolhas, 16'hFFFF);
      check("sat_descartes_hold", ifa.ContDescartes, 16'hFFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
